// File: rtl/up_down_mon.sv
// Passive monitor for an up/down counter: decodes step direction from successive
// valid samples and reports wraps, reversals and illegal steps with saturating tallies.
module up_down_mon #(
    parameter int WIDTH   = 5,
    parameter int TALLY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   count_in,
    input  logic               valid,
    input  logic               clear,
    output logic               dir,
    output logic               dir_valid,
    output logic               wrap_up,
    output logic               wrap_dn,
    output logic               rev,
    output logic               step_err,
    output logic [TALLY_W-1:0] err_count,
    output logic [TALLY_W-1:0] rev_count
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;
    localparam logic [1:0] S_DN   = 2'd3;

    localparam logic [WIDTH-1:0]   COUNT_MAX = '1;
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_prev;
    logic               r_dir;
    logic               r_wrap_up;
    logic               r_wrap_dn;
    logic               r_rev;
    logic               r_step_err;
    logic [TALLY_W-1:0] r_err_count;
    logic [TALLY_W-1:0] r_rev_count;

    logic [WIDTH-1:0]   w_delta;
    logic               w_is_up;
    logic               w_is_dn;
    logic [1:0]         w_state_next;
    logic               w_dir_next;
    logic               w_wrap_up_next;
    logic               w_wrap_dn_next;
    logic               w_rev_next;
    logic               w_step_err_next;

    // Modular difference: a wrap from max to 0 still decodes as a single up step.
    assign w_delta = count_in - r_prev;
    assign w_is_up = (w_delta == WIDTH'(1));
    assign w_is_dn = (w_delta == COUNT_MAX);

    always_comb begin
        w_state_next    = r_state;
        w_dir_next      = r_dir;
        w_wrap_up_next  = 1'b0;
        w_wrap_dn_next  = 1'b0;
        w_rev_next      = 1'b0;
        w_step_err_next = 1'b0;
        if (valid) begin
            case (r_state)
                S_INIT: begin
                    w_state_next = S_SYNC;
                end
                S_SYNC: begin
                    if (w_is_up) begin
                        w_state_next = S_UP;
                        w_dir_next   = 1'b1;
                    end else if (w_is_dn) begin
                        w_state_next = S_DN;
                        w_dir_next   = 1'b0;
                    end else begin
                        w_step_err_next = 1'b1;
                    end
                end
                S_UP: begin
                    if (w_is_dn) begin
                        w_state_next = S_DN;
                        w_dir_next   = 1'b0;
                        w_rev_next   = 1'b1;
                    end else if (!w_is_up) begin
                        w_state_next    = S_SYNC;
                        w_step_err_next = 1'b1;
                    end
                end
                default: begin
                    if (w_is_up) begin
                        w_state_next = S_UP;
                        w_dir_next   = 1'b1;
                        w_rev_next   = 1'b1;
                    end else if (!w_is_dn) begin
                        w_state_next    = S_SYNC;
                        w_step_err_next = 1'b1;
                    end
                end
            endcase
            // The first sample after init has no meaningful prev, so no wrap there.
            if (r_state != S_INIT) begin
                w_wrap_up_next = w_is_up && (r_prev == COUNT_MAX);
                w_wrap_dn_next = w_is_dn && (r_prev == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_prev      <= '0;
            r_dir       <= 1'b0;
            r_wrap_up   <= 1'b0;
            r_wrap_dn   <= 1'b0;
            r_rev       <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
            r_rev_count <= '0;
        end else if (clear) begin
            r_state     <= S_INIT;
            r_prev      <= '0;
            r_dir       <= 1'b0;
            r_wrap_up   <= 1'b0;
            r_wrap_dn   <= 1'b0;
            r_rev       <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
            r_rev_count <= '0;
        end else begin
            r_wrap_up  <= w_wrap_up_next;
            r_wrap_dn  <= w_wrap_dn_next;
            r_rev      <= w_rev_next;
            r_step_err <= w_step_err_next;
            if (valid) begin
                r_state <= w_state_next;
                r_prev  <= count_in;
                r_dir   <= w_dir_next;
                if (w_step_err_next && (r_err_count != TALLY_MAX)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (w_rev_next && (r_rev_count != TALLY_MAX)) begin
                    r_rev_count <= r_rev_count + 1'b1;
                end
            end
        end
    end

    assign dir       = r_dir;
    assign dir_valid = (r_state == S_UP) || (r_state == S_DN);
    assign wrap_up   = r_wrap_up;
    assign wrap_dn   = r_wrap_dn;
    assign rev       = r_rev;
    assign step_err  = r_step_err;
    assign err_count = r_err_count;
    assign rev_count = r_rev_count;

endmodule

// File: tb/tb_up_down_mon.sv
// Directed bench for up_down_mon: linear sample sequence with hand-computed flags and tallies.
module tb_up_down_mon;

    logic       clk;
    logic       reset;
    logic [4:0] count_in;
    logic       valid;
    logic       clear;
    logic       dir;
    logic       dir_valid;
    logic       wrap_up;
    logic       wrap_dn;
    logic       rev;
    logic       step_err;
    logic [7:0] err_count;
    logic [7:0] rev_count;

    int checks = 0;
    int errors = 0;

    up_down_mon #(.WIDTH(5), .TALLY_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .valid     (valid),
        .clear     (clear),
        .dir       (dir),
        .dir_valid (dir_valid),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .rev       (rev),
        .step_err  (step_err),
        .err_count (err_count),
        .rev_count (rev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected order: wrap_up wrap_dn rev step_err dir_valid dir err_count rev_count
    task automatic expect_all(input string tag, input logic wu, input logic wd, input logic rv,
                              input logic se, input logic dv, input logic dr,
                              input logic [7:0] ec, input logic [7:0] rc);
        check({tag, ".wrap_up"},   32'(wrap_up),   32'(wu));
        check({tag, ".wrap_dn"},   32'(wrap_dn),   32'(wd));
        check({tag, ".rev"},       32'(rev),       32'(rv));
        check({tag, ".step_err"},  32'(step_err),  32'(se));
        check({tag, ".dir_valid"}, 32'(dir_valid), 32'(dv));
        check({tag, ".dir"},       32'(dir),       32'(dr));
        check({tag, ".err_count"}, 32'(err_count), 32'(ec));
        check({tag, ".rev_count"}, 32'(rev_count), 32'(rc));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic [4:0] v, input logic vld, input logic clr);
        @(negedge clk);
        count_in = v;
        valid    = vld;
        clear    = clr;
        @(posedge clk);
        #1;
        $display("t=%0t count_in=%0d valid=%0b clear=%0b -> dir=%0b dv=%0b wu=%0b wd=%0b rev=%0b err=%0b ec=%0d rc=%0d",
                 $time, v, vld, clr, dir, dir_valid, wrap_up, wrap_dn, rev, step_err, err_count, rev_count);
    endtask

    initial begin
        reset    = 1'b0;
        count_in = '0;
        valid    = 1'b0;
        clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // Up counting
        cycle(5'd3, 1, 0);  expect_all("up_seed", 0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        cycle(5'd4, 1, 0);  expect_all("up_4",    0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd5, 1, 0);  expect_all("up_5",    0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd6, 1, 0);  expect_all("up_6",    0, 0, 0, 0, 1, 1, 8'd0, 8'd0);

        // Clear with a concurrent valid sample: sample is discarded
        cycle(5'd30, 1, 1); expect_all("clr1",    0, 0, 0, 0, 0, 0, 8'd0, 8'd0);

        // Wrap up, reversal, wrap down
        cycle(5'd30, 1, 0); expect_all("w_seed",  0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        cycle(5'd31, 1, 0); expect_all("w_31",    0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd0,  1, 0); expect_all("w_0",     1, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd1,  1, 0); expect_all("w_1",     0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd0,  1, 0); expect_all("rev_0",   0, 0, 1, 0, 1, 0, 8'd0, 8'd1);
        cycle(5'd31, 1, 0); expect_all("wdn_31",  0, 1, 0, 0, 1, 0, 8'd0, 8'd1);

        // Illegal steps (delta 8, then delta 0); pulse drops on an idle cycle
        cycle(5'd7,  1, 0); expect_all("ill_7",   0, 0, 0, 1, 0, 0, 8'd1, 8'd1);
        cycle(5'd20, 0, 0); expect_all("idle_a",  0, 0, 0, 0, 0, 0, 8'd1, 8'd1);
        cycle(5'd8,  1, 0); expect_all("ill_8",   0, 0, 0, 0, 1, 1, 8'd1, 8'd1);
        cycle(5'd8,  1, 0); expect_all("ill_8b",  0, 0, 0, 1, 0, 1, 8'd2, 8'd1);
        cycle(5'd9,  1, 0); expect_all("ill_9",   0, 0, 0, 0, 1, 1, 8'd2, 8'd1);

        // valid=0 holds state; count_in ignored
        cycle(5'd10, 1, 0); expect_all("hold_10", 0, 0, 0, 0, 1, 1, 8'd2, 8'd1);
        cycle(5'd11, 1, 0); expect_all("hold_11", 0, 0, 0, 0, 1, 1, 8'd2, 8'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(5'd20, 0, 0);
            expect_all($sformatf("hold_idle%0d", i), 0, 0, 0, 0, 1, 1, 8'd2, 8'd1);
        end
        cycle(5'd12, 1, 0); expect_all("hold_12", 0, 0, 0, 0, 1, 1, 8'd2, 8'd1);

        // Reversal tally saturation
        cycle(5'd0, 0, 1);  expect_all("clr2",    0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        cycle(5'd5, 1, 0);  expect_all("sat_seed",0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 300; i++) begin
            cycle((i % 2 == 1) ? 5'd6 : 5'd5, 1, 0);
            if (i == 1)   expect_all("sat_1",   0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
            if (i == 2)   expect_all("sat_2",   0, 0, 1, 0, 1, 0, 8'd0, 8'd1);
            if (i == 255) check("sat_255.rev_count", 32'(rev_count), 32'd254);
            if (i == 256) check("sat_256.rev_count", 32'(rev_count), 32'd255);
            if (i == 257) check("sat_257.rev_count", 32'(rev_count), 32'd255);
            if (i == 300) expect_all("sat_300", 0, 0, 1, 0, 1, 0, 8'd0, 8'd255);
        end
        cycle(5'd6, 0, 1);  expect_all("clr3",    0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        cycle(5'd7, 1, 0);  expect_all("reseed7", 0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        cycle(5'd8, 1, 0);  expect_all("reseed8", 0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd9, 1, 0);  expect_all("pre_rst", 0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
        cycle(5'd8, 1, 0);  expect_all("pre_rst2",0, 0, 1, 0, 1, 0, 8'd0, 8'd1);
        cycle(5'd9, 1, 0);  expect_all("pre_rst3",0, 0, 1, 0, 1, 1, 8'd0, 8'd2);

        // Asynchronous reset in the middle of a sample cycle while in S_UP
        @(negedge clk);
        count_in = 5'd10;
        valid    = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        $display("t=%0t async reset asserted mid-cycle", $time);
        expect_all("arst_now", 0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        expect_all("arst_edge", 0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;

        cycle(5'd15, 1, 0); expect_all("post_15", 0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        cycle(5'd14, 1, 0); expect_all("post_14", 0, 0, 0, 0, 1, 0, 8'd0, 8'd0);
        cycle(5'd13, 1, 0); expect_all("post_13", 0, 0, 0, 0, 1, 0, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
